// File: rtl/fifo_pkg.sv
// Shared types and helpers for the single-clock FIFO family.
// Latency: n/a (types and elaboration-time helpers only).
// Backpressure: n/a.
package fifo_pkg;

   // Registered status flags, all derived from the next occupancy value
   typedef struct packed {
      logic full;
      logic nearly_full;
      logic empty;
   } fifo_status_t;

   localparam int DEFAULT_DEPTH_BITS = 3;

   // Number of storage entries for a given pointer width
   function automatic int fifo_depth(input int depth_bits);
      return 1 << depth_bits;
   endfunction

   // A nearly-full threshold is meaningful only within 1..depth
   function automatic bit thresh_ok(input int thresh, input int depth);
      return (thresh >= 1) && (thresh <= depth);
   endfunction

endpackage

// File: rtl/fifo_dpram.sv
// Simple dual-port storage: one synchronous write port, one asynchronous read port.
// Latency: write visible on the read port the cycle after the write edge.
// Backpressure: none; the caller gates i_wr_en with its own full logic.
module fifo_dpram #(
   parameter int WIDTH          = 72,
   parameter int MAX_DEPTH_BITS = 3
) (
   input  logic                      i_clk,
   input  logic                      i_wr_en,
   input  logic [MAX_DEPTH_BITS-1:0] i_wr_addr,
   input  logic [WIDTH-1:0]          i_wr_dat,
   input  logic [MAX_DEPTH_BITS-1:0] i_rd_addr,
   output logic [WIDTH-1:0]          o_rd_dat
);

   localparam int DEPTH = 1 << MAX_DEPTH_BITS;

   logic [WIDTH-1:0] r_mem [DEPTH];

   // Store the write word; contents are never reset
   always_ff @(posedge i_clk) begin
      if (i_wr_en) begin
         r_mem[i_wr_addr] <= i_wr_dat;
      end
   end

   assign o_rd_dat = r_mem[i_rd_addr];

endmodule

// File: rtl/fallthrough_sync_fifo.sv
// Single-clock FIFO with fallthrough or registered read, occupancy count, optional sticky error flags.
// Latency: write-to-read 1 cycle in both modes; flags and data_count registered.
// Backpressure: writes dropped while full unless a read pops in the same cycle; reads ignored while empty.
// Optional feature macro: FALLTHROUGH_SYNC_FIFO_ERR_FLAGS_EN (sticky overflow/underflow + sim messages).
module fallthrough_sync_fifo
   import fifo_pkg::*;
#(
   parameter int WIDTH              = 72,
   parameter int MAX_DEPTH_BITS     = DEFAULT_DEPTH_BITS,
   parameter int NEARLY_FULL_THRESH = (2**MAX_DEPTH_BITS) - 1,
   parameter bit FALLTHROUGH        = 1'b1
) (
   input  logic                      clk,
   input  logic                      reset,
   input  logic [WIDTH-1:0]          din,
   input  logic                      wr_en,
   input  logic                      rd_en,
   output logic [WIDTH-1:0]          dout,
   output logic                      full,
   output logic                      nearly_full,
   output logic                      empty,
   output logic [MAX_DEPTH_BITS:0]   data_count,
   output logic                      overflow,
   output logic                      underflow
);

   localparam int DEPTH = fifo_depth(MAX_DEPTH_BITS);
   localparam int CNT_W = MAX_DEPTH_BITS + 1;
   // An out-of-range threshold falls back to DEPTH so nearly_full degenerates to full
   localparam int THRESH = thresh_ok(NEARLY_FULL_THRESH, DEPTH) ? NEARLY_FULL_THRESH : DEPTH;

   logic [MAX_DEPTH_BITS-1:0] r_wr_ptr;
   logic [MAX_DEPTH_BITS-1:0] r_rd_ptr;
   logic [CNT_W-1:0]          r_count;
   fifo_status_t              r_status;

   logic                      w_wr_acc;
   logic                      w_rd_acc;
   logic [CNT_W-1:0]          w_cnt_nxt;
   fifo_status_t              w_status_nxt;
   logic [WIDTH-1:0]          w_rd_dat;

   // A write into a full FIFO is still accepted when a read frees the head slot in the same cycle
   assign w_wr_acc = wr_en && (!r_status.full || rd_en);
   assign w_rd_acc = rd_en && !r_status.empty;

   // Next occupancy and the flags derived from it
   always_comb begin
      w_cnt_nxt = r_count;
      if (w_wr_acc && !w_rd_acc) begin
         w_cnt_nxt = r_count + CNT_W'(1);
      end else if (w_rd_acc && !w_wr_acc) begin
         w_cnt_nxt = r_count - CNT_W'(1);
      end
      w_status_nxt.full        = (w_cnt_nxt == CNT_W'(DEPTH));
      w_status_nxt.nearly_full = (w_cnt_nxt >= CNT_W'(THRESH));
      w_status_nxt.empty       = (w_cnt_nxt == '0);
   end

   // Pointer, count and flag registers; reset overrides any concurrent enable
   always_ff @(posedge clk) begin
      if (reset) begin
         r_wr_ptr <= '0;
         r_rd_ptr <= '0;
         r_count  <= '0;
         r_status <= '{full: 1'b0, nearly_full: 1'b0, empty: 1'b1};
      end else begin
         if (w_wr_acc) begin
            r_wr_ptr <= r_wr_ptr + MAX_DEPTH_BITS'(1);
         end
         if (w_rd_acc) begin
            r_rd_ptr <= r_rd_ptr + MAX_DEPTH_BITS'(1);
         end
         r_count  <= w_cnt_nxt;
         r_status <= w_status_nxt;
      end
   end

   fifo_dpram #(
      .WIDTH          (WIDTH),
      .MAX_DEPTH_BITS (MAX_DEPTH_BITS)
   ) u_mem (
      .i_clk     (clk),
      .i_wr_en   (w_wr_acc && !reset),
      .i_wr_addr (r_wr_ptr),
      .i_wr_dat  (din),
      .i_rd_addr (r_rd_ptr),
      .o_rd_dat  (w_rd_dat)
   );

   assign full        = r_status.full;
   assign nearly_full = r_status.nearly_full;
   assign empty       = r_status.empty;
   assign data_count  = r_count;

   generate
      if (FALLTHROUGH) begin : g_fallthrough
         // Head word shown directly; forced to zero so an empty FIFO never exposes stale data
         assign dout = r_status.empty ? '0 : w_rd_dat;
      end else begin : g_registered
         logic [WIDTH-1:0] r_dout;
         // Capture the popped word; hold otherwise
         always_ff @(posedge clk) begin
            if (reset) begin
               r_dout <= '0;
            end else if (w_rd_acc) begin
               r_dout <= w_rd_dat;
            end
         end
         assign dout = r_dout;
      end
   endgenerate

`ifdef FALLTHROUGH_SYNC_FIFO_ERR_FLAGS_EN
   logic r_overflow;
   logic r_underflow;
   logic w_ovf_evt;
   logic w_unf_evt;

   // Write while full is an error only when no read made room for it
   assign w_ovf_evt = wr_en && r_status.full && !rd_en;
   assign w_unf_evt = rd_en && r_status.empty;

   // Sticky error flags, cleared only by reset
   always_ff @(posedge clk) begin
      if (reset) begin
         r_overflow  <= 1'b0;
         r_underflow <= 1'b0;
      end else begin
         r_overflow  <= r_overflow  | w_ovf_evt;
         r_underflow <= r_underflow | w_unf_evt;
      end
   end

   assign overflow  = r_overflow;
   assign underflow = r_underflow;

`ifndef SYNTHESIS
   // Report each offending cycle in simulation
   always_ff @(posedge clk) begin
      if (!reset && w_ovf_evt) begin
         $error("fallthrough_sync_fifo: write while full, data dropped");
      end
      if (!reset && w_unf_evt) begin
         $error("fallthrough_sync_fifo: read while empty, ignored");
      end
   end
`endif
`else
   assign overflow  = 1'b0;
   assign underflow = 1'b0;
`endif

endmodule

// File: tb/tb_fallthrough_sync_fifo.sv
// Directed bench: one fallthrough instance and one registered-read instance, depth 8, 8-bit data.
module tb_fallthrough_sync_fifo;
   import fifo_pkg::*;

`ifdef FALLTHROUGH_SYNC_FIFO_ERR_FLAGS_EN
   localparam logic EXP_ERR = 1'b1;
`else
   localparam logic EXP_ERR = 1'b0;
`endif

   logic clk;
   int   checks   = 0;
   int   failures = 0;

   // Instance A: fallthrough mode
   logic       a_reset, a_wr_en, a_rd_en;
   logic [7:0] a_din, a_dout;
   logic       a_full, a_nf, a_empty, a_ovf, a_unf;
   logic [3:0] a_count;

   // Instance B: registered read mode
   logic       b_reset, b_wr_en, b_rd_en;
   logic [7:0] b_din, b_dout;
   logic       b_full, b_nf, b_empty, b_ovf, b_unf;
   logic [3:0] b_count;

   fallthrough_sync_fifo #(
      .WIDTH(8), .MAX_DEPTH_BITS(3), .NEARLY_FULL_THRESH(7), .FALLTHROUGH(1'b1)
   ) dut_a (
      .clk(clk), .reset(a_reset), .din(a_din), .wr_en(a_wr_en), .rd_en(a_rd_en),
      .dout(a_dout), .full(a_full), .nearly_full(a_nf), .empty(a_empty),
      .data_count(a_count), .overflow(a_ovf), .underflow(a_unf)
   );

   fallthrough_sync_fifo #(
      .WIDTH(8), .MAX_DEPTH_BITS(3), .NEARLY_FULL_THRESH(7), .FALLTHROUGH(1'b0)
   ) dut_b (
      .clk(clk), .reset(b_reset), .din(b_din), .wr_en(b_wr_en), .rd_en(b_rd_en),
      .dout(b_dout), .full(b_full), .nearly_full(b_nf), .empty(b_empty),
      .data_count(b_count), .overflow(b_ovf), .underflow(b_unf)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic tick();
      @(posedge clk);
      #1;
   endtask

   task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
      checks++;
      assert (obs === exp) else begin
         failures++;
         $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
      end
   endtask

   initial begin
      a_reset = 1'b1; a_wr_en = 1'b0; a_rd_en = 1'b0; a_din = 8'h00;
      b_reset = 1'b1; b_wr_en = 1'b0; b_rd_en = 1'b0; b_din = 8'h00;
      tick();
      tick();

      // Reset state
      chk("rst_empty", 32'(a_empty), 32'd1);
      chk("rst_full",  32'(a_full),  32'd0);
      chk("rst_nf",    32'(a_nf),    32'd0);
      chk("rst_count", 32'(a_count), 32'd0);
      chk("rst_dout",  32'(a_dout),  32'd0);
      chk("rst_ovf",   32'(a_ovf),   32'd0);
      chk("rst_unf",   32'(a_unf),   32'd0);
      chk("rst_b_dout", 32'(b_dout), 32'd0);
      a_reset = 1'b0;
      b_reset = 1'b0;

      // Fill with 0x01..0x08
      for (int i = 1; i <= 8; i++) begin
         a_din = 8'(i); a_wr_en = 1'b1;
         tick();
         chk("fill_count", 32'(a_count), 32'(i));
         chk("fill_nf",    32'(a_nf),    32'(i >= 7));
         chk("fill_full",  32'(a_full),  32'(i == 8));
         chk("fill_empty", 32'(a_empty), 32'd0);
         if (i == 1) chk("fill_head", 32'(a_dout), 32'h01);
      end

      // Write while full with no read: dropped
      a_din = 8'hAA; a_wr_en = 1'b1;
      tick();
      a_wr_en = 1'b0;
      chk("ovf_count", 32'(a_count), 32'd8);
      chk("ovf_full",  32'(a_full),  32'd1);
      chk("ovf_flag",  32'(a_ovf),   32'(EXP_ERR));
      chk("ovf_head",  32'(a_dout),  32'h01);

      // Drain in order
      a_rd_en = 1'b1;
      for (int i = 1; i <= 8; i++) begin
         chk("drain_dout", 32'(a_dout), 32'(i));
         tick();
      end
      a_rd_en = 1'b0;
      chk("drain_empty", 32'(a_empty), 32'd1);
      chk("drain_dout0", 32'(a_dout),  32'd0);
      chk("drain_count", 32'(a_count), 32'd0);
      chk("drain_unf",   32'(a_unf),   32'd0);
      chk("ovf_sticky",  32'(a_ovf),   32'(EXP_ERR));

      // Refill with 0x10..0x17, then 20 simultaneous read+write cycles across the wrap
      a_wr_en = 1'b1;
      for (int i = 0; i < 8; i++) begin
         a_din = 8'(8'h10 + i);
         tick();
      end
      chk("refill_full", 32'(a_full), 32'd1);
      a_rd_en = 1'b1;
      for (int k = 0; k < 20; k++) begin
         a_din = 8'(8'h18 + k);
         chk("wrap_dout", 32'(a_dout), 32'(8'h10 + k));
         tick();
         chk("wrap_count", 32'(a_count), 32'd8);
         chk("wrap_full",  32'(a_full),  32'd1);
      end
      a_wr_en = 1'b0;
      for (int k = 0; k < 8; k++) begin
         chk("wrap_tail", 32'(a_dout), 32'(8'h24 + k));
         tick();
      end
      a_rd_en = 1'b0;
      chk("wrap_empty", 32'(a_empty), 32'd1);

      // Empty with write+read: read ignored, write accepted
      a_din = 8'h55; a_wr_en = 1'b1; a_rd_en = 1'b1;
      tick();
      a_wr_en = 1'b0; a_rd_en = 1'b0;
      chk("unf_count", 32'(a_count), 32'd1);
      chk("unf_flag",  32'(a_unf),   32'(EXP_ERR));
      chk("unf_empty", 32'(a_empty), 32'd0);
      chk("unf_dout",  32'(a_dout),  32'h55);

      // Grow to 5 words, then reset with wr_en held high
      a_wr_en = 1'b1;
      for (int i = 0; i < 4; i++) begin
         a_din = 8'(8'h61 + i);
         tick();
      end
      chk("pre_rst_count", 32'(a_count), 32'd5);
      a_reset = 1'b1; a_din = 8'h77;
      tick();
      chk("mid_rst_count", 32'(a_count), 32'd0);
      chk("mid_rst_empty", 32'(a_empty), 32'd1);
      chk("mid_rst_ovf",   32'(a_ovf),   32'd0);
      chk("mid_rst_unf",   32'(a_unf),   32'd0);
      chk("mid_rst_dout",  32'(a_dout),  32'd0);
      a_reset = 1'b0; a_wr_en = 1'b0; a_rd_en = 1'b1;
      tick();
      a_rd_en = 1'b0;
      chk("post_rst_empty", 32'(a_empty), 32'd1);
      chk("post_rst_dout",  32'(a_dout),  32'd0);
      chk("post_rst_count", 32'(a_count), 32'd0);

      // Registered read mode
      b_wr_en = 1'b1; b_din = 8'h11;
      tick();
      b_din = 8'h22;
      tick();
      b_wr_en = 1'b0;
      chk("reg_count2", 32'(b_count), 32'd2);
      chk("reg_idle0",  32'(b_dout),  32'd0);
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      chk("reg_rd1",    32'(b_dout),  32'h11);
      chk("reg_count1", 32'(b_count), 32'd1);
      tick();
      chk("reg_hold1",  32'(b_dout),  32'h11);
      b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      chk("reg_rd2",    32'(b_dout),  32'h22);
      chk("reg_empty",  32'(b_empty), 32'd1);
      tick();
      tick();
      chk("reg_hold2",  32'(b_dout),  32'h22);
      b_wr_en = 1'b1; b_din = 8'h33;
      tick();
      b_wr_en = 1'b0; b_rd_en = 1'b1;
      tick();
      b_rd_en = 1'b0;
      chk("reg_lat1",   32'(b_dout),  32'h33);
      chk("reg_ovf",    32'(b_ovf),   32'd0);

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

endmodule

// File: doc/fallthrough_sync_fifo.md
# fallthrough_sync_fifo

- Single-clock, parameterised successor to the team's small fallthrough FIFO.
- Generalises width, depth and nearly-full threshold; adds a selectable read mode (fallthrough or registered), an occupancy count, and optional sticky overflow/underflow flags.
- Used as the general buffering primitive between pipeline stages inside one clock domain, where the clock-domain-crossing variant is unnecessary.

## Interface
Parameters:
- WIDTH, 72, data word width in bits.
- MAX_DEPTH_BITS, 3, log2 of depth; DEPTH = 2**MAX_DEPTH_BITS, minimum 1.
- NEARLY_FULL_THRESH, 2**MAX_DEPTH_BITS-1, count at or above which nearly_full asserts; legal range 1..DEPTH.
- FALLTHROUGH, 1, read mode: 1 = head word presented on dout while not empty; 0 = registered read, word appears on dout one cycle after rd_en.

Ports:
- clk  input  1  sole clock, all logic on rising edge.
- reset  input  1  synchronous, active-high reset.
- din  input  WIDTH  write data.
- wr_en  input  1  push din.
- rd_en  input  1  pop head word.
- dout  output  WIDTH  read data.
- full  output  1  count == DEPTH.
- nearly_full  output  1  count >= NEARLY_FULL_THRESH.
- empty  output  1  count == 0.
- data_count  output  MAX_DEPTH_BITS+1  current occupancy, 0..DEPTH.
- overflow  output  1  sticky: write attempted while full without simultaneous read.
- underflow  output  1  sticky: read attempted while empty.

## Operation
- Storage: DEPTH x WIDTH array, write pointer and read pointer MAX_DEPTH_BITS wide, wrapping naturally modulo DEPTH.
- Accepted write = wr_en && (!full || rd_en). Accepted read = rd_en && !empty.
- Count update: +1 on write only, -1 on read only, unchanged on both or neither.
- Full plus wr_en plus rd_en: both accepted; count stays DEPTH; full stays 1.
- Empty plus wr_en plus rd_en: read ignored (underflow event), write accepted, count becomes 1.
- Rejected write: no pointer or count change; data dropped.
- FALLTHROUGH=1:
  - dout = mem[rd_ptr] combinationally while !empty.
  - dout = 0 while empty.
- FALLTHROUGH=0:
  - dout register loads mem[rd_ptr] on an accepted read.
  - Otherwise dout holds its value.
- All flags and data_count are registered; they are derived from the next count value.
- Reset:
  - Pointers, count, dout register, overflow and underflow all go to 0.
  - empty=1, full=0, nearly_full=0.
  - Contents are discarded.
  - wr_en and rd_en are ignored in any cycle where reset=1, including mid-operation.
- No state machine beyond the pointer/count datapath; the two modes differ only in the output stage.

## Timing
- Write accepted at edge N: empty falls and data_count increments after edge N. In FALLTHROUGH=1, dout shows the word in the cycle after edge N.
- Read accepted at edge N:
  - FALLTHROUGH=1: the next word, or 0, is visible after edge N.
  - FALLTHROUGH=0: the popped word is on dout after edge N.
- Write-to-read minimum latency: 1 cycle in both modes.
- full, nearly_full and empty change only on clock edges, never combinationally from wr_en or rd_en.
- Throughput: one write and one read per cycle, sustained.
- Sticky flags set at the edge following the offending cycle; they clear only on reset.

## Configuration
- Macro FALLTHROUGH_SYNC_FIFO_ERR_FLAGS_EN.
- Defined:
  - overflow and underflow are driven as described above.
  - Simulation-only $error messages are emitted on each overflow or underflow event.
- Undefined:
  - overflow and underflow are tied to 0.
  - No error logic or messages are generated.
  - Ports remain present so instantiations are identical in both builds.

## Structure
- Shared package fifo_pkg:
  - fifo_status_t packed struct {full, nearly_full, empty}.
  - Localparam helper for DEPTH from MAX_DEPTH_BITS.
  - Function checking that the threshold lies within 1..DEPTH.
- One sub-module, fifo_dpram: simple dual-port storage array with synchronous write and asynchronous read, parameterised by WIDTH and MAX_DEPTH_BITS.
- Pointer, count, flag and output-stage logic live in the top module.

## Test plan
- Reset then 8 writes 0x01..0x08 (DEPTH=8, FALLTHROUGH=1): full=1 after the 8th edge, nearly_full=1 after the 7th, data_count=8; 8 reads return 0x01..0x08 in order, then empty=1 and dout=0.
- Full FIFO with wr_en=1 and din=0xAA, no read: data_count stays 8, contents unchanged, overflow=1 (macro defined) or 0 (undefined).
- Full FIFO with wr_en and rd_en together for 20 cycles with an incrementing din: count stays 8; output sequence is continuous across pointer wrap.
- Empty FIFO with wr_en=1, rd_en=1, din=0x55: underflow=1, data_count=1; dout=0x55 next cycle in FALLTHROUGH=1.
- FALLTHROUGH=0: write 0x11, 0x22; pulse rd_en twice; dout=0x11 after the first read edge and 0x22 after the second; dout holds when rd_en=0.
- Reset asserted with 5 words stored and wr_en=1: next cycle data_count=0, empty=1, sticky flags cleared; the following read shows no stale data.
